alu_control_seq: RTL and testbench

Parametrised successor to the single-cycle ALU control decoder for the MIPS datapath. It keeps combinational ALUOp/funct decoding for single-cycle operations and adds a multi-cycle sequencer for R-type MULT/MULTU, which writes dedicated HI/LO registers. It sits in the execute stage beside the ALU and drives a stall to the PC and pipeline registers while a multiply is in flight.

---
 rtl/alu_control_seq_pkg.sv | 39 +++
 rtl/mult_seq_core.sv | 75 +++++++
 rtl/alu_control_seq.sv | 89 ++++++++
 tb/tb_alu_control_seq.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_control_seq_pkg.sv
// Shared encodings for the ALU control decoder and the multiply sequencer:
// ALUOp class codes, funct codes, 4-bit ALU operation codes and FSM states.
package alu_control_seq_pkg;

    // ALUOp class codes from the main control unit
    localparam logic [2:0] ALUOP_RTYPE  = 3'b111;
    localparam logic [2:0] ALUOP_ADDI   = 3'b100;
    localparam logic [2:0] ALUOP_ORI    = 3'b101;
    localparam logic [2:0] ALUOP_BRANCH = 3'b001;
    localparam logic [2:0] ALUOP_INC    = 3'b110;

    // R-type funct field codes
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    // ALU select codes
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_NOR  = 4'b0010;
    localparam logic [3:0] OP_ADD  = 4'b0011;
    localparam logic [3:0] OP_BR   = 4'b0100;
    localparam logic [3:0] OP_INC  = 4'b1111;
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_MFHI = 4'b1011;
    localparam logic [3:0] OP_MFLO = 4'b1100;
    localparam logic [3:0] OP_DEF  = 4'b1001;

    // Multiply sequencer states
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/mult_seq_core.sv
// Shift-add multiply datapath: operand magnitudes, accumulator, iteration
// counter, sign fix-up and the architectural HI/LO registers.
module mult_seq_core
    import alu_control_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  run,
    input  logic                  is_signed,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  last,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

    localparam int W = DATA_WIDTH;

    logic [2*W-1:0]     acc;
    logic [W-1:0]       mcand;
    logic [W-1:0]       mplier;
    logic               neg;
    logic [CNT_WIDTH-1:0] cnt;

    logic [W-1:0]       mag_a;
    logic [W-1:0]       mag_b;
    logic [W:0]         sum;
    logic [2*W-1:0]     acc_next;
    logic [2*W-1:0]     prod;

    // Signed operands become unsigned magnitudes; the most negative value
    // negates to itself, which is its correct unsigned magnitude.
    assign mag_a = (is_signed && a[W-1]) ? (~a + 1'b1) : a;
    assign mag_b = (is_signed && b[W-1]) ? (~b + 1'b1) : b;

    assign last = (cnt == CNT_WIDTH'(1));

    // One shift-add step; the add keeps its carry so the product is exact
    always_comb begin
        sum      = {1'b0, acc[2*W-1:W]} + (mplier[0] ? {1'b0, mcand} : {(W+1){1'b0}});
        acc_next = (2*W)'({sum, acc[W-1:0]} >> 1);
        prod     = neg ? (~acc_next + 1'b1) : acc_next;
    end

    // Operand capture on load, iterate while running, commit HI/LO on the last step
    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= mag_a;
            mplier <= mag_b;
            neg    <= is_signed & (a[W-1] ^ b[W-1]);
            cnt    <= CNT_WIDTH'(DATA_WIDTH);
        end else if (run) begin
            acc    <= acc_next;
            mplier <= mplier >> 1;
            cnt    <= cnt - 1'b1;
            if (last) begin
                {hi, lo} <= prod;
            end
        end
    end

endmodule

// File: rtl/alu_control_seq.sv
// Execute-stage ALU control: combinational ALUOp/funct decode plus a
// multi-cycle MULT/MULTU sequencer that stalls the pipeline while busy.
module alu_control_seq
    import alu_control_seq_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ALUOP_WIDTH = 3,
    parameter int CNT_WIDTH   = $clog2(DATA_WIDTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ALUOP_WIDTH-1:0] ALUOp,
    input  logic [5:0]             ALUFunction,
    input  logic [DATA_WIDTH-1:0]  OperandA,
    input  logic [DATA_WIDTH-1:0]  OperandB,
    output logic [3:0]             ALUOperation,
    output logic                   stall,
    output logic                   done,
    output logic [DATA_WIDTH-1:0]  HI,
    output logic [DATA_WIDTH-1:0]  LO
);

    logic [1:0] state;
    logic [1:0] state_next;
    logic       is_rtype;
    logic       is_mult;
    logic       accept;
    logic       running;
    logic       last;

    assign is_rtype = (ALUOp == ALUOP_WIDTH'(ALUOP_RTYPE));
    assign is_mult  = is_rtype && (ALUFunction == F_MULT || ALUFunction == F_MULTU);
    assign running  = (state == ST_RUN);
    // A new multiply is taken only when the sequencer is free (IDLE or DONE)
    assign accept   = start && is_mult && (state == ST_IDLE || state == ST_DONE);
    assign stall    = running || accept;
    assign done     = (state == ST_DONE);

    // Priority decode of ALUOp/funct into the ALU select code
    always_comb begin
        ALUOperation = OP_DEF;
        if      (is_rtype && ALUFunction == F_AND)      ALUOperation = OP_AND;
        else if (is_rtype && ALUFunction == F_OR)       ALUOperation = OP_OR;
        else if (is_rtype && ALUFunction == F_NOR)      ALUOperation = OP_NOR;
        else if (is_rtype && ALUFunction == F_ADD)      ALUOperation = OP_ADD;
        else if (ALUOp == ALUOP_WIDTH'(ALUOP_ADDI))     ALUOperation = OP_ADD;
        else if (ALUOp == ALUOP_WIDTH'(ALUOP_ORI))      ALUOperation = OP_OR;
        else if (ALUOp == ALUOP_WIDTH'(ALUOP_BRANCH))   ALUOperation = OP_BR;
        else if (ALUOp == ALUOP_WIDTH'(ALUOP_INC))      ALUOperation = OP_INC;
        else if (is_mult)                               ALUOperation = OP_MUL;
        else if (is_rtype && ALUFunction == F_MFHI)     ALUOperation = OP_MFHI;
        else if (is_rtype && ALUFunction == F_MFLO)     ALUOperation = OP_MFLO;
    end

    // Sequencer next state; DONE can chain straight into another RUN
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = ST_RUN;
            ST_RUN:  if (last)   state_next = ST_DONE;
            ST_DONE: state_next = accept ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State register; reset aborts any multiply in flight
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    mult_seq_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .run       (running),
        .is_signed (ALUFunction == F_MULT),
        .a         (OperandA),
        .b         (OperandB),
        .last      (last),
        .hi        (HI),
        .lo        (LO)
    );

endmodule

// File: tb/tb_alu_control_seq.sv
// Bench for alu_control_seq: table-driven decode sweep plus multiply
// sequences checked against a product scoreboard.
module tb_alu_control_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   ALUOp;
    logic [5:0]   ALUFunction;
    logic [W-1:0] OperandA;
    logic [W-1:0] OperandB;
    logic [3:0]   ALUOperation;
    logic         stall;
    logic         done;
    logic [W-1:0] HI;
    logic [W-1:0] LO;

    int checks = 0;
    int failures = 0;
    logic [2*W-1:0] sb_q[$];

    typedef struct {
        logic [2:0] op;
        logic [5:0] fn;
        logic       st;
        logic [3:0] exp;
    } dec_vec_t;

    dec_vec_t dec[15];

    alu_control_seq #(.DATA_WIDTH(W), .ALUOP_WIDTH(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .ALUOp        (ALUOp),
        .ALUFunction  (ALUFunction),
        .OperandA     (OperandA),
        .OperandB     (OperandB),
        .ALUOperation (ALUOperation),
        .stall        (stall),
        .done         (done),
        .HI           (HI),
        .LO           (LO)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input bit sgn);
        logic signed [2*W-1:0] sx, sy;
        if (sgn) begin
            sx = {{W{x[W-1]}}, x};
            sy = {{W{y[W-1]}}, y};
            return sx * sy;
        end
        return {{W{1'b0}}, x} * {{W{1'b0}}, y};
    endfunction

    // Move to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard: every done pulse must match the oldest pending product
    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) chk("done_without_pending_mult", 64'(sb_q.size()), 64'd1);
            else chk("product_hilo", {HI, LO}, sb_q.pop_front());
        end
    end

    // Full multiply from cycle 0 (entry) to the done cycle (exit); optional
    // MULT starts in cycles nf..nt land while RUN and must be ignored.
    task automatic mult_seq(input logic [W-1:0] x, input logic [W-1:0] y, input bit sgn,
                            input int nf, input int nt);
        start = 1'b1; ALUOp = 3'b111; ALUFunction = sgn ? 6'b011000 : 6'b011001;
        OperandA = x; OperandB = y;
        sb_q.push_back(model(x, y, sgn));
        #1 chk("stall_cycle0", 64'(stall), 64'd1);
        chk("aluop_mult", 64'(ALUOperation), 64'hA);
        step();
        for (int c = 1; c <= W; c++) begin
            if (c >= nf && c <= nt) begin
                start = 1'b1; ALUFunction = 6'b011000; OperandA = 32'd100; OperandB = 32'd100;
            end else begin
                start = 1'b0; OperandA = '0; OperandB = '0;
            end
            #1 chk($sformatf("stall_run_c%0d", c), 64'(stall), 64'd1);
            chk($sformatf("done_low_c%0d", c), 64'(done), 64'd0);
            step();
        end
        start = 1'b0;
        #1 chk("done_pulse", 64'(done), 64'd1);
        chk("stall_retire", 64'(stall), 64'd0);
    endtask

    initial begin
        dec[0]  = '{3'b111, 6'b100101, 1'b0, 4'h1};
        dec[1]  = '{3'b100, 6'b010101, 1'b0, 4'h3};
        dec[2]  = '{3'b110, 6'b000000, 1'b0, 4'hF};
        dec[3]  = '{3'b111, 6'b010010, 1'b0, 4'hC};
        dec[4]  = '{3'b010, 6'b000000, 1'b0, 4'h9};
        dec[5]  = '{3'b111, 6'b100100, 1'b0, 4'h0};
        dec[6]  = '{3'b111, 6'b100111, 1'b1, 4'h2};
        dec[7]  = '{3'b111, 6'b100000, 1'b0, 4'h3};
        dec[8]  = '{3'b101, 6'b011000, 1'b1, 4'h1};
        dec[9]  = '{3'b001, 6'b111111, 1'b1, 4'h4};
        dec[10] = '{3'b111, 6'b011000, 1'b0, 4'hA};
        dec[11] = '{3'b111, 6'b011001, 1'b0, 4'hA};
        dec[12] = '{3'b111, 6'b010000, 1'b0, 4'hB};
        dec[13] = '{3'b111, 6'b111111, 1'b1, 4'h9};
        dec[14] = '{3'b011, 6'b011000, 1'b1, 4'h9};

        reset = 1'b1; start = 1'b0; ALUOp = '0; ALUFunction = '0; OperandA = '0; OperandB = '0;
        step(); step();
        reset = 1'b0;
        #1 chk("rst_hi", 64'(HI), 64'd0);
        chk("rst_lo", 64'(LO), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        step();

        // Decode sweep; non-multiply starts must not stall or touch the FSM
        for (int i = 0; i < 15; i++) begin
            ALUOp = dec[i].op; ALUFunction = dec[i].fn; start = dec[i].st;
            #1 chk($sformatf("decode_%0d", i), 64'(ALUOperation), 64'(dec[i].exp));
            chk($sformatf("decode_stall_%0d", i), 64'(stall), 64'd0);
            step();
        end
        start = 1'b0;
        #1 chk("decode_state_idle", 64'(dut.state), 64'd0);
        chk("decode_hilo_kept", {HI, LO}, 64'd0);
        step();

        // Signed, unsigned and most-negative corner products
        mult_seq(32'd7, 32'hFFFF_FFFD, 1'b1, 0, -1);
        chk("mult_7x-3_hi", 64'(HI), 64'hFFFF_FFFF);
        chk("mult_7x-3_lo", 64'(LO), 64'hFFFF_FFEB);
        step();
        mult_seq(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, -1);
        chk("multu_max_hilo", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
        step();
        mult_seq(32'h8000_0000, 32'h8000_0000, 1'b1, 0, -1);
        chk("mult_minneg_hilo", {HI, LO}, 64'h4000_0000_0000_0000);
        step();
        mult_seq(32'h8000_0000, 32'd3, 1'b1, 0, -1);
        step();

        // Back-to-back: second multiply accepted in the done cycle
        mult_seq(32'd5, 32'd6, 1'b1, 0, -1);
        chk("b2b_first_lo", 64'(LO), 64'h1E);
        mult_seq(32'd2, 32'd3, 1'b1, 0, -1);
        chk("b2b_second_lo", 64'(LO), 64'h6);
        step();

        // Starts during RUN are ignored
        mult_seq(32'd7, 32'hFFFF_FFFD, 1'b1, 5, 8);
        chk("ignored_start_lo", 64'(LO), 64'hFFFF_FFEB);
        step();

        // Reset mid-multiply aborts without a done pulse
        start = 1'b1; ALUOp = 3'b111; ALUFunction = 6'b011000; OperandA = 32'd9; OperandB = 32'd9;
        step();
        start = 1'b0;
        for (int c = 1; c < 10; c++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1 chk("abort_hi", 64'(HI), 64'd0);
        chk("abort_lo", 64'(LO), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_stall", 64'(stall), 64'd0);
        chk("abort_state", 64'(dut.state), 64'd0);
        for (int c = 0; c < 40; c++) begin
            step();
            chk("abort_no_done", 64'(done), 64'd0);
        end
        mult_seq(32'd9, 32'd9, 1'b1, 0, -1);
        chk("after_abort_lo", 64'(LO), 64'h51);
        step();

        // Reset wins over a simultaneous multiply start
        reset = 1'b1; start = 1'b1; ALUFunction = 6'b011001; OperandA = 32'd4; OperandB = 32'd4;
        step();
        reset = 1'b0; start = 1'b0;
        #1 chk("rst_wins_state", 64'(dut.state), 64'd0);
        chk("rst_wins_stall", 64'(stall), 64'd0);
        for (int c = 0; c < 36; c++) step();
        chk("rst_wins_hilo", {HI, LO}, 64'd0);
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
